inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 62 ++++++
 rtl/inst_encoder_if.sv | 26 ++
 rtl/inst_encoder_pack.sv | 37 +++
 rtl/inst_encoder.sv | 140 ++++++++++++++
 tb/tb_inst_encoder.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder and decoder.
// Holds opcode constants, instruction-word field positions and widths,
// the encoder FSM state type and a word-packing helper.
package inst_encoder_pkg;

  localparam int unsigned WORD_W = 17;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned ECNT_W = 8;
  localparam int unsigned WCNT_W = 9;

  // Field LSB positions within the 17-bit word
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned DA_LSB  = 9;
  localparam int unsigned AA_LSB  = 6;
  localparam int unsigned BA_LSB  = 3;
  localparam int unsigned SH_LSB  = 0;

  localparam logic [OPC_W-1:0] OP_NOP     = 5'd0;
  localparam logic [OPC_W-1:0] OP_ADD     = 5'd1;
  localparam logic [OPC_W-1:0] OP_OUT     = 5'd2;
  localparam logic [OPC_W-1:0] OP_SLT     = 5'd3;
  localparam logic [OPC_W-1:0] OP_AND     = 5'd4;
  localparam logic [OPC_W-1:0] OP_LD      = 5'd5;
  localparam logic [OPC_W-1:0] OP_SBI     = 5'd6;
  localparam logic [OPC_W-1:0] OP_LSL     = 5'd7;
  localparam logic [OPC_W-1:0] OP_IN      = 5'd8;
  localparam logic [OPC_W-1:0] OP_XRI     = 5'd9;
  localparam logic [OPC_W-1:0] OP_ADI     = 5'd10;
  localparam logic [OPC_W-1:0] OP_BZ      = 5'd11;
  localparam logic [OPC_W-1:0] OP_BNZ     = 5'd12;
  localparam logic [OPC_W-1:0] OP_ST      = 5'd13;
  localparam logic [OPC_W-1:0] OP_MOVA    = 5'd14;
  localparam logic [OPC_W-1:0] OP_JMP     = 5'd15;
  // First illegal opcode; everything at or above it is rejected
  localparam logic [OPC_W-1:0] OP_ILLEGAL = 5'd16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  function automatic word_t pack_word(
    input logic [OPC_W-1:0] opc,
    input logic [REG_W-1:0] da,
    input logic [REG_W-1:0] aa,
    input logic [REG_W-1:0] ba,
    input logic [REG_W-1:0] sh
  );
    pack_word = (WORD_W'(opc) << OPC_LSB) |
                (WORD_W'(da)  << DA_LSB)  |
                (WORD_W'(aa)  << AA_LSB)  |
                (WORD_W'(ba)  << BA_LSB)  |
                (WORD_W'(sh)  << SH_LSB);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-set handshake channel into the instruction encoder.
// master: field producer (drives valid, fields, last; receives ready)
// slave : encoder (receives valid, fields, last; drives ready)
interface inst_encoder_if;
  import inst_encoder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OPC_W-1:0] in_opcode;
  logic [REG_W-1:0] in_rd;
  logic [REG_W-1:0] in_ra;
  logic [REG_W-1:0] in_rb;
  logic [REG_W-1:0] in_sh;
  logic [OFF_W-1:0] in_off;
  logic             in_last;

  modport master (
    output in_valid, in_opcode, in_rd, in_ra, in_rb, in_sh, in_off, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_ra, in_rb, in_sh, in_off, in_last,
    output in_ready
  );
endinterface

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational instruction packer.
// Ports: opcode/rd/ra/rb/sh/off field inputs; word = packed 17-bit
// instruction (zero when illegal); illegal = opcode outside 0-15.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] rb,
  input  logic [REG_W-1:0] sh,
  input  logic [OFF_W-1:0] off,
  output word_t            word,
  output logic             illegal
);

  always_comb begin
    word    = '0;
    illegal = (opcode >= OP_ILLEGAL);
    case (opcode)
      OP_NOP: word = '0;
      OP_ADD, OP_OUT, OP_SLT, OP_AND, OP_SBI, OP_XRI, OP_ST:
        word = pack_word(opcode, rd, ra, rb, '0);
      OP_LSL:
        word = pack_word(opcode, rd, ra, rb, sh);
      OP_LD, OP_IN, OP_ADI, OP_MOVA:
        word = pack_word(opcode, rd, ra, '0, '0);
      // Offset occupies the BA and SH slots, [5:0]
      OP_BZ, OP_BNZ:
        word = pack_word(opcode, '0, ra, off[5:3], off[2:0]);
      OP_JMP:
        word = pack_word(opcode, '0, '0, off[5:3], off[2:0]);
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: loads a session of encoded instructions into instruction
// memory starting at base_addr.
// Ports: clk, rst (sync, active high); start/base_addr open a session in
// IDLE; in_if (slave) carries field sets; imem_stall back-pressures the
// write port imem_we/imem_addr/imem_wdata; busy, done (pulse),
// err_illegal (pulse), err_count (saturating), word_count report status.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  inst_encoder_if.slave     in_if,
  input  logic              imem_stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output word_t             imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ECNT_W-1:0] err_count,
  output logic [WCNT_W-1:0] word_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pending_q, pending_d;
  logic              end_seen_q, end_seen_d;
  word_t             wdata_q, wdata_d;
  logic              err_illegal_q, err_illegal_d;
  logic [ECNT_W-1:0] err_count_q, err_count_d;
  logic [WCNT_W-1:0] word_count_q, word_count_d;

  word_t pack_word_w;
  logic  pack_illegal;
  logic  ready;
  logic  fire;
  logic  wr_done;

  inst_pack u_pack (
    .opcode  (in_if.in_opcode),
    .rd      (in_if.in_rd),
    .ra      (in_if.in_ra),
    .rb      (in_if.in_rb),
    .sh      (in_if.in_sh),
    .off     (in_if.in_off),
    .word    (pack_word_w),
    .illegal (pack_illegal)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    pending_d     = pending_q;
    end_seen_d    = end_seen_q;
    wdata_d       = wdata_q;
    err_illegal_d = 1'b0;
    err_count_d   = err_count_q;
    word_count_d  = word_count_q;

    ready   = (state_q == ST_LOAD) && !pending_q && !end_seen_q;
    fire    = in_if.in_valid && ready;
    wr_done = pending_q && !imem_stall;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_LOAD;
          ptr_d        = base_addr;
          pending_d    = 1'b0;
          end_seen_d   = 1'b0;
          err_count_d  = '0;
          word_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (wr_done) begin
          pending_d    = 1'b0;
          word_count_d = word_count_q + 9'd1;
          // Top of memory ends the session instead of wrapping
          if (ptr_q == 8'hFF) end_seen_d = 1'b1;
          else                ptr_d      = ptr_q + 8'd1;
        end
        // fire and wr_done are exclusive: fire needs !pending_q
        if (fire) begin
          if (pack_illegal) begin
            err_illegal_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end else begin
            pending_d = 1'b1;
            wdata_d   = pack_word_w;
          end
          if (in_if.in_last) end_seen_d = 1'b1;
        end
        if (end_seen_d && !pending_d) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        end_seen_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      pending_q     <= 1'b0;
      end_seen_q    <= 1'b0;
      wdata_q       <= '0;
      err_illegal_q <= 1'b0;
      err_count_q   <= '0;
      word_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      pending_q     <= pending_d;
      end_seen_q    <= end_seen_d;
      wdata_q       <= wdata_d;
      err_illegal_q <= err_illegal_d;
      err_count_q   <= err_count_d;
      word_count_q  <= word_count_d;
    end
  end

  // Write enable and ready are masked by rst so a pending write is dropped
  // in the very cycle reset is asserted, not one cycle later.
  assign imem_we        = pending_q && !rst;
  assign in_if.in_ready = ready && !rst;
  assign imem_addr      = ptr_q;
  assign imem_wdata     = wdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign err_illegal    = err_illegal_q;
  assign err_count      = err_count_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        imem_stall;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [16:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err_illegal;
  logic [7:0]  err_count;
  logic [8:0]  word_count;

  inst_encoder_if in_if();

  inst_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .in_if       (in_if),
    .imem_stall  (imem_stall),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal),
    .err_count   (err_count),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  sh;
    logic [5:0]  off;
    logic        last;
    logic [16:0] exp_word;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [4:0] opc, input logic [2:0] rd, input logic [2:0] ra,
                            input logic [2:0] rb, input logic [2:0] sh, input logic [5:0] off,
                            input logic last);
    in_if.in_opcode = opc;
    in_if.in_rd     = rd;
    in_if.in_ra     = ra;
    in_if.in_rb     = rb;
    in_if.in_sh     = sh;
    in_if.in_off    = off;
    in_if.in_last   = last;
  endtask

  // Presents one field set and returns #1 after the edge that accepted it.
  task automatic send(input logic [4:0] opc, input logic [2:0] rd, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [2:0] sh, input logic [5:0] off,
                      input logic last);
    int n;
    set_fields(opc, rd, ra, rb, sh, off, last);
    in_if.in_valid = 1'b1;
    n = 0;
    while (!in_if.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(in_if.in_ready), 32'd1);
    tick();
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
  endtask

  task automatic start_session(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
    chk("session_busy", 32'(busy), 32'd1);
    chk("session_ready", 32'(in_if.in_ready), 32'd1);
    chk("session_wc_clear", 32'(word_count), 32'd0);
    chk("session_ec_clear", 32'(err_count), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(imem_we), 32'd0);
    chk({tag, "_addr"},  32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    chk({tag, "_ready"}, 32'(in_if.in_ready), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_eill"},  32'(err_illegal), 32'd0);
    chk({tag, "_ecnt"},  32'(err_count), 32'd0);
    chk({tag, "_wcnt"},  32'(word_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit open;
    int exp_ptr, exp_wc, exp_ec;

    // opc, rd, ra, rb, sh, off, last, expected word, expected illegal
    vecs[0]  = '{5'd7,  3'd7, 3'd0, 3'd1, 3'd5, 6'h00, 1'b0, 17'h07E0D, 1'b0}; // LSL
    vecs[1]  = '{5'd15, 3'd5, 3'd3, 3'd6, 3'd7, 6'h2A, 1'b0, 17'h0F02A, 1'b0}; // JMP
    vecs[2]  = '{5'd11, 3'd4, 3'd5, 3'd2, 3'd1, 6'h15, 1'b0, 17'h0B155, 1'b0}; // BZ
    vecs[3]  = '{5'd12, 3'd7, 3'd7, 3'd0, 3'd0, 6'h3F, 1'b0, 17'h0C1FF, 1'b0}; // BNZ
    vecs[4]  = '{5'd5,  3'd3, 3'd6, 3'd7, 3'd7, 6'h3F, 1'b0, 17'h05780, 1'b0}; // LD
    vecs[5]  = '{5'd13, 3'd2, 3'd1, 3'd4, 3'd3, 6'h00, 1'b0, 17'h0D460, 1'b0}; // ST
    vecs[6]  = '{5'd16, 3'd1, 3'd1, 3'd1, 3'd1, 6'h01, 1'b0, 17'h00000, 1'b1}; // illegal
    vecs[7]  = '{5'd14, 3'd6, 3'd2, 3'd5, 3'd5, 6'h00, 1'b0, 17'h0EC80, 1'b0}; // MOVA
    vecs[8]  = '{5'd9,  3'd1, 3'd1, 3'd1, 3'd7, 6'h00, 1'b0, 17'h09248, 1'b0}; // XRI
    vecs[9]  = '{5'd2,  3'd0, 3'd7, 3'd7, 3'd7, 6'h00, 1'b0, 17'h021F8, 1'b0}; // OUT
    vecs[10] = '{5'd3,  3'd5, 3'd0, 3'd2, 3'd1, 6'h00, 1'b0, 17'h03A10, 1'b0}; // SLT
    vecs[11] = '{5'd4,  3'd1, 3'd1, 3'd1, 3'd0, 6'h00, 1'b0, 17'h04248, 1'b0}; // AND
    vecs[12] = '{5'd6,  3'd7, 3'd7, 3'd7, 3'd6, 6'h00, 1'b0, 17'h06FF8, 1'b0}; // SBI
    vecs[13] = '{5'd8,  3'd4, 3'd3, 3'd2, 3'd1, 6'h3F, 1'b0, 17'h088C0, 1'b0}; // IN
    vecs[14] = '{5'd10, 3'd2, 3'd5, 3'd7, 3'd0, 6'h00, 1'b0, 17'h0A540, 1'b0}; // ADI
    vecs[15] = '{5'd0,  3'd7, 3'd7, 3'd7, 3'd7, 6'h3F, 1'b1, 17'h00000, 1'b0}; // NOP last
    vecs[16] = '{5'd16, 3'd1, 3'd2, 3'd3, 3'd0, 6'h00, 1'b0, 17'h00000, 1'b1}; // illegal 16
    vecs[17] = '{5'd31, 3'd7, 3'd7, 3'd7, 3'd7, 6'h3F, 1'b0, 17'h00000, 1'b1}; // illegal 31
    vecs[18] = '{5'd0,  3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 1'b1, 17'h00000, 1'b0}; // NOP last
    vecs[19] = '{5'd20, 3'd3, 3'd3, 3'd3, 3'd3, 6'h00, 1'b1, 17'h00000, 1'b1}; // illegal last

    rst = 1'b1; start = 1'b0; base_addr = '0; imem_stall = 1'b0;
    in_if.in_valid = 1'b0;
    set_fields('0, '0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single ADD session
    start_session(8'h10);
    send(5'd1, 3'd1, 3'd2, 3'd3, 3'd0, 6'h00, 1'b1);
    chk("add_we", 32'(imem_we), 32'd1);
    chk("add_addr", 32'(imem_addr), 32'h10);
    chk("add_wdata", 32'(imem_wdata), 32'h01298);
    chk("add_ready_pend", 32'(in_if.in_ready), 32'd0);
    tick();
    chk("add_done", 32'(done), 32'd1);
    chk("add_we_off", 32'(imem_we), 32'd0);
    chk("add_wc", 32'(word_count), 32'd1);
    tick();
    chk("add_done_pulse", 32'(done), 32'd0);
    chk("add_idle", 32'(busy), 32'd0);

    // Table-driven sessions
    open = 1'b0;
    exp_ptr = 0; exp_wc = 0; exp_ec = 0;
    for (int i = 0; i < 20; i++) begin
      if (!open) begin
        start_session(8'h20);
        open = 1'b1;
        exp_ptr = 32'h20; exp_wc = 0; exp_ec = 0;
      end
      send(vecs[i].opc, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].sh, vecs[i].off, vecs[i].last);
      if (vecs[i].exp_ill) begin
        exp_ec++;
        chk($sformatf("v%0d_eill", i), 32'(err_illegal), 32'd1);
        chk($sformatf("v%0d_we", i), 32'(imem_we), 32'd0);
        chk($sformatf("v%0d_ecnt", i), 32'(err_count), 32'(exp_ec));
      end else begin
        chk($sformatf("v%0d_we", i), 32'(imem_we), 32'd1);
        chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(exp_ptr));
        chk($sformatf("v%0d_wdata", i), 32'(imem_wdata), 32'(vecs[i].exp_word));
        chk($sformatf("v%0d_eill", i), 32'(err_illegal), 32'd0);
        tick();
        exp_ptr++;
        exp_wc++;
        chk($sformatf("v%0d_wcnt", i), 32'(word_count), 32'(exp_wc));
      end
      if (vecs[i].last) begin
        chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
        chk($sformatf("v%0d_end_wc", i), 32'(word_count), 32'(exp_wc));
        chk($sformatf("v%0d_end_ec", i), 32'(err_count), 32'(exp_ec));
        tick();
        chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        open = 1'b0;
      end
    end

    // Stall during a write, with a stray start in LOAD
    start_session(8'h40);
    send(5'd1, 3'd1, 3'd2, 3'd3, 3'd0, 6'h00, 1'b0);
    imem_stall = 1'b1;
    start = 1'b1; base_addr = 8'h99;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_we", c), 32'(imem_we), 32'd1);
      chk($sformatf("stall%0d_addr", c), 32'(imem_addr), 32'h40);
      chk($sformatf("stall%0d_wdata", c), 32'(imem_wdata), 32'h01298);
      chk($sformatf("stall%0d_ready", c), 32'(in_if.in_ready), 32'd0);
      chk($sformatf("stall%0d_wc", c), 32'(word_count), 32'd0);
      tick();
      start = 1'b0;
    end
    imem_stall = 1'b0;
    chk("stall_release_we", 32'(imem_we), 32'd1);
    tick();
    chk("stall_wc", 32'(word_count), 32'd1);
    chk("stall_we_off", 32'(imem_we), 32'd0);
    chk("stall_addr_next", 32'(imem_addr), 32'h41);
    chk("stall_ready", 32'(in_if.in_ready), 32'd1);
    send(5'd0, 3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 1'b1);
    tick();
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_wc_final", 32'(word_count), 32'd2);
    tick();

    // Address range end at 0xFF
    start_session(8'hFE);
    send(5'd1, 3'd1, 3'd1, 3'd1, 3'd0, 6'h00, 1'b0);
    chk("wrap_addr0", 32'(imem_addr), 32'hFE);
    chk("wrap_data0", 32'(imem_wdata), 32'h01248);
    tick();
    send(5'd4, 3'd2, 3'd2, 3'd2, 3'd0, 6'h00, 1'b0);
    chk("wrap_addr1", 32'(imem_addr), 32'hFF);
    chk("wrap_data1", 32'(imem_wdata), 32'h04490);
    tick();
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_wc", 32'(word_count), 32'd2);
    chk("wrap_ready", 32'(in_if.in_ready), 32'd0);
    set_fields(5'd1, 3'd3, 3'd3, 3'd3, 3'd0, 6'h00, 1'b0);
    in_if.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("wrap_third%0d_we", c), 32'(imem_we), 32'd0);
      chk($sformatf("wrap_third%0d_ready", c), 32'(in_if.in_ready), 32'd0);
    end
    in_if.in_valid = 1'b0;
    chk("wrap_no_wrap", 32'(imem_addr), 32'hFF);
    chk("wrap_wc_hold", 32'(word_count), 32'd2);

    // Reset right after an accepted transfer
    start_session(8'h50);
    send(5'd1, 3'd1, 3'd2, 3'd3, 3'd0, 6'h00, 1'b0);
    chk("rst_pre_we", 32'(imem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_we_masked", 32'(imem_we), 32'd0);
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    chk_reset_outputs("postrst");
    start_session(8'h60);
    send(5'd1, 3'd1, 3'd2, 3'd3, 3'd0, 6'h00, 1'b1);
    chk("after_rst_addr", 32'(imem_addr), 32'h60);
    chk("after_rst_wdata", 32'(imem_wdata), 32'h01298);
    tick();
    chk("after_rst_done", 32'(done), 32'd1);
    chk("after_rst_wc", 32'(word_count), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
